// File: rtl/regfile_view_scanner.sv
// rtl/regfile_view_scanner.sv - steps a regfile debug index, captures the word, scans it onto 8 seven-segment digits
// Optional auto stepping is compiled in with REGFILE_VIEW_AUTO_STEP_EN.
module regfile_view_scanner #(
  parameter int DEBOUNCE_CYCLES  = 20,
  parameter int SCAN_DIV         = 4,
  parameter int AUTO_STEP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_step,
  input  logic        auto_mode,
  output logic [4:0]  test_addr,
  input  logic [31:0] test_data,
  output logic [4:0]  led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_LATCH  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_btn_meta;
  logic            r_btn_sync;
  logic            r_btn_filt;
  logic            r_btn_filt_q;
  logic [DB_W-1:0] r_db_cnt;

  logic [4:0]      r_addr;
  logic [4:0]      r_led;
  logic [31:0]     r_display_word;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_digit;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;

  logic       w_btn_evt;
  logic       w_auto_evt;
  logic       w_step_evt;
  logic       w_advance;
  logic       w_capture;
  logic       w_div_tc;
  logic [2:0] w_digit_nxt;
  logic [3:0] w_nibble;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_btn_meta <= btn_step;
      r_btn_sync <= r_btn_meta;
    end
  end

  // The filtered level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_filt   <= 1'b0;
      r_btn_filt_q <= 1'b0;
      r_db_cnt     <= '0;
    end else begin
      r_btn_filt_q <= r_btn_filt;
      if (r_btn_sync == r_btn_filt) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_btn_filt <= r_btn_sync;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_btn_evt = r_btn_filt & ~r_btn_filt_q;

`ifdef REGFILE_VIEW_AUTO_STEP_EN
  localparam int AUTO_W = (AUTO_STEP_CYCLES > 1) ? $clog2(AUTO_STEP_CYCLES) : 1;

  logic [AUTO_W-1:0] r_auto_cnt;
  logic              w_auto_tc;

  assign w_auto_tc  = (r_auto_cnt == AUTO_W'(AUTO_STEP_CYCLES - 1));
  assign w_auto_evt = auto_mode & w_auto_tc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_auto_cnt <= '0;
    end else if (!auto_mode || w_auto_tc) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + 1'b1;
    end
  end
`else
  logic w_unused_auto;
  assign w_unused_auto = auto_mode;
  assign w_auto_evt    = 1'b0;
`endif

  assign w_step_evt = w_btn_evt | w_auto_evt;

  // Reset lands in LATCH so entry 0 is shown without a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_LATCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_step_evt) w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_LATCH;
      S_LATCH:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_advance = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE:  w_advance = w_step_evt;
      S_LATCH: w_capture = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr         <= '0;
      r_led          <= '0;
      r_display_word <= '0;
    end else begin
      if (w_advance) begin
        r_addr <= r_addr + 5'd1;
      end
      if (w_capture) begin
        r_display_word <= test_data;
        r_led          <= r_addr;
      end
    end
  end

  // an and seg are both derived from the upcoming digit so they switch together.
  assign w_div_tc    = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_digit_nxt = w_div_tc ? r_digit + 3'd1 : r_digit;
  assign w_nibble    = r_display_word[{w_digit_nxt, 2'b00} +: 4];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div   <= '0;
      r_digit <= '0;
      r_an    <= 8'hFE;
      r_seg   <= 8'hC0;
    end else begin
      r_div   <= w_div_tc ? '0 : r_div + 1'b1;
      r_digit <= w_digit_nxt;
      r_an    <= ~(8'h01 << w_digit_nxt);
      r_seg   <= hex_to_seg(w_nibble);
    end
  end

  assign test_addr = r_addr;
  assign led       = r_led;
  assign an        = r_an;
  assign seg       = r_seg;

endmodule

// File: tb/tb_regfile_view_scanner.sv
// tb/tb_regfile_view_scanner.sv - randomized self-checking bench for regfile_view_scanner
// Auto-step checks follow REGFILE_VIEW_AUTO_STEP_EN when it is defined for the build.
module tb_regfile_view_scanner;

  localparam int DB   = 20;
  localparam int SD   = 4;
  localparam int AUTO = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        btn_step = 1'b0;
  logic        auto_mode = 1'b0;
  logic [4:0]  test_addr;
  logic [31:0] test_data;
  logic [4:0]  led;
  logic [7:0]  an;
  logic [7:0]  seg;

  logic [31:0] regs [32];
  logic [7:0]  hex7 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_addr;
  logic [31:0] exp_word;

  regfile_view_scanner #(
    .DEBOUNCE_CYCLES (DB),
    .SCAN_DIV        (SD),
    .AUTO_STEP_CYCLES(AUTO)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .btn_step (btn_step),
    .auto_mode(auto_mode),
    .test_addr(test_addr),
    .test_data(test_data),
    .led      (led),
    .an       (an),
    .seg      (seg)
  );

  assign test_data = regs[test_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scan_check(input string tag, input logic [31:0] word);
    int         k;
    logic [7:0] exp_an;
    logic [3:0] nib;
    for (int i = 0; i < 8 * SD; i++) begin
      @(negedge clk);
      k = 0;
      for (int b = 0; b < 8; b++) if (!an[b]) k = b;
      exp_an = ~(8'h01 << k);
      nib = word[4*k +: 4];
      check({tag, "_an"}, 32'(an), 32'(exp_an));
      check({tag, "_seg"}, 32'(seg), 32'(hex7[nib]));
    end
  endtask

  task automatic check_index(input string tag);
    check({tag, "_addr"}, 32'(test_addr), 32'(exp_addr));
    check({tag, "_led"}, 32'(led), 32'(exp_addr));
  endtask

  task automatic press(input int hold);
    btn_step = 1'b1;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    repeat (DB + 8) @(negedge clk);
    exp_addr = (exp_addr + 1) % 32;
    exp_word = regs[exp_addr];
  endtask

  task automatic bounce(input int cycles, input int max_gap);
    int left;
    left = cycles;
    while (left > 0) begin
      int gap;
      gap = $urandom_range(max_gap, 1);
      btn_step = ~btn_step;
      repeat (gap) @(negedge clk);
      left -= gap;
    end
  endtask

  initial begin
    logic [31:0] old_word;
    bit          seen;
    logic [7:0]  exp_an;
    int          start;

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h0;
    regs[5] = 32'h0000_003F;
    exp_addr = 0;
    exp_word = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_addr", 32'(test_addr), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_an", 32'(an), 32'hFE);
    check("rst_seg", 32'(seg), 32'hC0);

    resetn = 1'b1;
    for (int j = 1; j <= 9 * SD; j++) begin
      @(negedge clk);
      exp_an = ~(8'h01 << ((j / SD) % 8));
      check("boot_an", 32'(an), 32'(exp_an));
      check("boot_seg", 32'(seg), 32'hC0);
      if (j == 3) check_index("boot");
    end

    for (int p = 0; p < 5; p++) press($urandom_range(DB + 15, DB + 4));
    check_index("five");
    check("five_word_src", exp_word, 32'h0000_003F);
    scan_check("five", exp_word);

    bounce(50, 3);
    press(DB + 10);
    check_index("bounce3");
    bounce(40, 6);
    press($urandom_range(DB + 12, DB + 4));
    check_index("bounce_rand");
    scan_check("bounce_rand", exp_word);

    while (exp_addr != 31) press($urandom_range(DB + 12, DB + 4));
    check_index("at31");
    scan_check("at31", exp_word);
    press($urandom_range(DB + 12, DB + 4));
    check_index("wrap");
    scan_check("wrap", exp_word);

    old_word = exp_word;
    regs[0] = $urandom | 32'h1;
    repeat (5) @(negedge clk);
    scan_check("not_live", old_word);
    press($urandom_range(DB + 12, DB + 4));
    check_index("after_idle_write");
    scan_check("after_idle_write", exp_word);

    start = test_addr;
    seen = 1'b0;
    btn_step = 1'b1;
    for (int c = 0; c < DB + 30 && !seen; c++) begin
      @(negedge clk);
      if (test_addr != 5'(start)) seen = 1'b1;
    end
    check("settle_wait_timeout", 32'(seen), 32'd1);
    btn_step = 1'b0;
    resetn = 1'b0;
    #1;
    check("mid_rst_addr", 32'(test_addr), 32'd0);
    check("mid_rst_an", 32'(an), 32'hFE);
    check("mid_rst_seg", 32'(seg), 32'hC0);
    check("mid_rst_led", 32'(led), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_addr = 0;
    exp_word = regs[0];
    repeat (3) @(negedge clk);
    check_index("post_rst");
    scan_check("post_rst", exp_word);

    auto_mode = 1'b1;
    repeat (AUTO * 33) @(negedge clk);
    auto_mode = 1'b0;
`ifdef REGFILE_VIEW_AUTO_STEP_EN
    exp_addr = (exp_addr + 33) % 32;
    exp_word = regs[exp_addr];
`endif
    repeat (5) @(negedge clk);
    check_index("auto");
    scan_check("auto", exp_word);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
